// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector with per-bit mask, overlap mode and a
// saturating match counter.
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   en, din         : serial bit stream, din sampled only when en=1
//   cfg_load        : loads cfg_pattern/cfg_mask/cfg_overlap and restarts detection
//   cnt_clr         : synchronous clear of match_cnt (wins over a same-edge match)
//   match           : Mealy output, combinational from state and din
//   match_q         : match delayed by one clock
//   match_cnt       : saturating count of matches
module seq_detect_prog #(
  parameter int              PAT_W       = 4,
  parameter int              CNT_W       = 8,
  parameter logic [PAT_W-1:0] RST_PATTERN = 4'b1011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             match,
  output logic             match_q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [PAT_W-2:0] hist_q,    hist_d;
  logic [FILL_W-1:0] fill_q,   fill_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [PAT_W-1:0] mask_q,    mask_d;
  logic             overlap_q, overlap_d;
  logic             match_q_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  logic [PAT_W-1:0] win;
  logic             hit;

  // Window: stored history followed by the bit arriving this cycle, oldest in MSB.
  assign win = {hist_q, din};
  // A full history is required before any compare counts, even with an all-zero mask.
  assign hit = (fill_q == FILL_MAX) && (((win ^ pattern_q) & mask_q) == '0);
  assign match = ~rst & en & ~cfg_load & hit;

  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    mask_d    = mask_q;
    overlap_d = overlap_q;
    cnt_d     = cnt_q;
    match_q_d = match;

    if (cfg_load) begin
      pattern_d = cfg_pattern;
      mask_d    = cfg_mask;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
    end else if (en) begin
      hist_d = win[PAT_W-2:0];
      if (match && !overlap_q) begin
        // Non-overlap: the bits just consumed cannot start the next match.
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= RST_PATTERN;
      mask_q    <= '1;
      overlap_q <= 1'b0;
      match_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      mask_q    <= mask_d;
      overlap_q <= overlap_d;
      match_q   <= match_q_d;
      cnt_q     <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: a vector table on a default instance and a
// hand-written saturation / clear sequence on a CNT_W=2 instance.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       din;
  logic       cfg_load;
  logic [3:0] cfg_pattern;
  logic [3:0] cfg_mask;
  logic       cfg_overlap;
  logic       cnt_clr;

  logic       match_a, match_q_a;
  logic [7:0] cnt_a;
  logic       match_b, match_q_b;
  logic [1:0] cnt_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detect_prog u_dut_a (
    .clk(clk), .rst(rst), .en(en), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .match(match_a), .match_q(match_q_a), .match_cnt(cnt_a)
  );

  seq_detect_prog #(.CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .match(match_b), .match_q(match_q_b), .match_cnt(cnt_b)
  );

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       din;
    logic       ld;
    logic [3:0] pat;
    logic [3:0] mask;
    logic       ov;
    logic       clr;
    logic       m;
    logic       mq;
    logic [7:0] cnt;
  } vec_t;

  vec_t vec[$];

  task automatic row(input logic r, input logic e, input logic d, input logic ld,
                     input logic [3:0] p, input logic [3:0] mk, input logic ov,
                     input logic clr, input logic m, input logic mq, input logic [7:0] c);
    vec_t v;
    v.rst = r; v.en = e; v.din = d; v.ld = ld; v.pat = p; v.mask = mk;
    v.ov = ov; v.clr = clr; v.m = m; v.mq = mq; v.cnt = c;
    vec.push_back(v);
  endtask

  // Plain data bit with everything else idle.
  task automatic bit_row(input logic e, input logic d, input logic m, input logic mq,
                         input logic [7:0] c);
    row(1'b0, e, d, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, m, mq, c);
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] got,
                       input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s step%0d: got %0d want %0d", name, idx, got, want);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic d, input logic ld,
                       input logic [3:0] p, input logic [3:0] mk, input logic ov,
                       input logic clr);
    rst = r; en = e; din = d; cfg_load = ld; cfg_pattern = p; cfg_mask = mk;
    cfg_overlap = ov; cnt_clr = clr;
  endtask

  logic [12:0] stream_b;
  logic [12:0] expm_b;
  int          hits_b;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Reset state, and match held low under reset even with a valid bit.
    row(1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    row(1, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    // Default pattern 1011, non-overlap: stream 1,0,1,1,0,1,1.
    bit_row(1, 1, 0, 0, 0);
    bit_row(1, 0, 0, 0, 0);
    bit_row(1, 1, 0, 0, 0);
    bit_row(1, 1, 1, 0, 0);
    bit_row(1, 0, 0, 1, 1);
    bit_row(1, 1, 0, 0, 1);
    bit_row(1, 1, 0, 0, 1);
    // Load 1011 overlap (din ignored on the load edge), clear counter.
    row(0, 1, 1, 1, 4'b1011, 4'b1111, 1, 1, 0, 0, 1);
    bit_row(1, 1, 0, 0, 0);
    bit_row(1, 0, 0, 0, 0);
    bit_row(1, 1, 0, 0, 0);
    bit_row(1, 1, 1, 0, 0);
    bit_row(1, 0, 0, 1, 1);
    bit_row(1, 1, 0, 0, 1);
    bit_row(1, 1, 1, 0, 1);
    bit_row(0, 0, 0, 1, 2);
    // Non-overlap again; 1,0,1,1 with 3-cycle en=0 gaps carrying din=1.
    row(0, 0, 0, 1, 4'b1011, 4'b1111, 0, 1, 0, 0, 2);
    bit_row(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) bit_row(0, 1, 0, 0, 0);
    bit_row(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) bit_row(0, 1, 0, 0, 0);
    bit_row(1, 1, 0, 0, 0);
    // History now 101 with full fill: din=1 would match if en were ignored.
    for (int i = 0; i < 3; i++) bit_row(0, 1, 0, 0, 0);
    bit_row(1, 1, 1, 0, 0);
    bit_row(0, 0, 0, 1, 1);
    // Mask 1101: bit 1 is don't care, 1001 matches 1011.
    row(0, 0, 0, 1, 4'b1011, 4'b1101, 0, 1, 0, 0, 1);
    bit_row(1, 1, 0, 0, 0);
    bit_row(1, 0, 0, 0, 0);
    bit_row(1, 0, 0, 0, 0);
    bit_row(1, 1, 1, 0, 0);
    // 1111 differs in a compared bit: no match.
    bit_row(1, 1, 0, 1, 1);
    bit_row(1, 1, 0, 0, 1);
    bit_row(1, 1, 0, 0, 1);
    bit_row(1, 1, 0, 0, 1);
    // All-zero mask, overlap: matches once the history is full, every bit after.
    row(0, 0, 0, 1, 4'b0000, 4'b0000, 1, 0, 0, 0, 1);
    bit_row(1, 0, 0, 0, 1);
    bit_row(1, 1, 0, 0, 1);
    bit_row(1, 0, 0, 0, 1);
    bit_row(1, 1, 1, 0, 1);
    bit_row(1, 0, 1, 1, 2);
    bit_row(0, 0, 0, 1, 3);
    // Partial 1,0,1 then async reset (counter 3 clears at once), then 1 and 1,0,1,1.
    row(0, 0, 0, 1, 4'b1011, 4'b1111, 0, 0, 0, 0, 3);
    bit_row(1, 1, 0, 0, 3);
    bit_row(1, 0, 0, 0, 3);
    bit_row(1, 1, 0, 0, 3);
    row(1, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    bit_row(1, 1, 0, 0, 0);
    bit_row(1, 1, 0, 0, 0);
    bit_row(1, 0, 0, 0, 0);
    bit_row(1, 1, 0, 0, 0);
    bit_row(1, 1, 1, 0, 0);
    bit_row(0, 0, 0, 1, 1);

    for (int i = 0; i < vec.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vec[i].rst, vec[i].en, vec[i].din, vec[i].ld, vec[i].pat, vec[i].mask,
            vec[i].ov, vec[i].clr);
      #3;
      check("match",     i, {7'd0, match_a},   {7'd0, vec[i].m});
      check("match_q",   i, {7'd0, match_q_a}, {7'd0, vec[i].mq});
      check("match_cnt", i, cnt_a,             vec[i].cnt);
    end

    // CNT_W=2 instance: overlap 1011 on 1011011011011 gives 4 matches, count sticks at 3.
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    #3;
    check("b_rst_cnt", 0, {6'd0, cnt_b}, 8'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, 4'b1111, 1'b1, 1'b0);
    stream_b = 13'b1011011011011;
    expm_b   = 13'b0001001001001;
    hits_b   = 0;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b1, stream_b[12-i], 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
      #3;
      check("b_match", i, {7'd0, match_b}, {7'd0, expm_b[12-i]});
      check("b_cnt",   i, {6'd0, cnt_b}, (hits_b > 3) ? 8'd3 : 8'(hits_b));
      if (expm_b[12-i]) hits_b++;
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    #3;
    check("b_sat_cnt", 13, {6'd0, cnt_b}, 8'd3);
    check("b_match",   13, {7'd0, match_b}, 8'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    #3;
    check("b_match", 14, {7'd0, match_b}, 8'd0);
    // Clear coincides with a match: clear wins.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    #3;
    check("b_match_clr", 15, {7'd0, match_b}, 8'd1);
    check("b_cnt",       15, {6'd0, cnt_b}, 8'd3);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    #3;
    check("b_cnt_clr", 16, {6'd0, cnt_b}, 8'd0);
    check("b_match_q", 16, {7'd0, match_q_b}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
